// File: rtl/uart_sync_fifo_if.sv
// Bus-side signal bundle of uart_sync_fifo: master is the UART control logic, slave is the FIFO.
interface uart_sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  Flush;
  logic                  Clear_Err;
  logic                  Write;
  logic [DATA_WIDTH-1:0] Data_In;
  logic                  Read;
  logic [DATA_WIDTH-1:0] Data_Out;
  logic [ADDR_WIDTH:0]   AE_Thresh;
  logic [ADDR_WIDTH:0]   AF_Thresh;
  logic [ADDR_WIDTH:0]   Count;
  logic [3:0]            Fifo_Status;
  logic                  Overflow;
  logic                  Underflow;

  modport master (
    output Flush, Clear_Err, Write, Data_In, Read, AE_Thresh, AF_Thresh,
    input  Data_Out, Count, Fifo_Status, Overflow, Underflow
  );

  modport slave (
    input  Flush, Clear_Err, Write, Data_In, Read, AE_Thresh, AF_Thresh,
    output Data_Out, Count, Fifo_Status, Overflow, Underflow
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock UART byte FIFO with occupancy count, programmable thresholds and sticky errors.
// Define UART_FIFO_FWFT_EN for first-word fall-through output; default is registered read data.
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input logic             Clk,
  input logic             Reset,
  uart_sync_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_reg;
  logic [ADDR_WIDTH:0]   rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  empty;
  logic                  full;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_evt;
  logic                  unf_evt;

  assign wr_addr = wr_ptr_reg[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr_reg[ADDR_WIDTH-1:0];
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_addr == rd_addr) && (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]);

  // A full FIFO still takes a write when the same cycle frees a slot; Flush masks everything.
  assign rd_acc  = bus.Read & ~empty & ~bus.Flush;
  assign wr_acc  = bus.Write & (~full | rd_acc) & ~bus.Flush;
  assign ovf_evt = bus.Write & ~wr_acc & ~bus.Flush;
  assign unf_evt = bus.Read & ~rd_acc & ~bus.Flush;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (bus.Flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (rd_acc) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_reg + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
    end
  end

  // A fresh error event outranks Clear_Err in the same cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (ovf_evt)            overflow_reg  <= 1'b1;
      else if (bus.Clear_Err) overflow_reg  <= 1'b0;
      if (unf_evt)            underflow_reg <= 1'b1;
      else if (bus.Clear_Err) underflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_acc) mem[wr_addr] <= bus.Data_In;
  end

`ifdef UART_FIFO_FWFT_EN
  assign bus.Data_Out = empty ? '0 : mem[rd_addr];
`else
  logic [DATA_WIDTH-1:0] data_out_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)      data_out_reg <= '0;
    else if (rd_acc) data_out_reg <= mem[rd_addr];
  end

  assign bus.Data_Out = data_out_reg;
`endif

  assign bus.Count       = count_reg;
  assign bus.Overflow    = overflow_reg;
  assign bus.Underflow   = underflow_reg;
  assign bus.Fifo_Status = {(count_reg <= bus.AE_Thresh), (count_reg >= bus.AF_Thresh), full, empty};
endmodule
